truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
Sequencing controller for two-input (generalised N-input) combinational test pairs, such as a gate-level and an expression-level version of the same function. On `start` it walks the shared input vector through all 2^N_IN combinations and waits a settle time after each step. It then compares the reference output against the DUT output and reports a mismatch count, the first failing vector and a pass/fail flag. It replaces hand-written #1 stimulus sequences in module testbenches with a clocked, self-checking sequencer.

Parameters:
- N_IN, 2, width of the input vector driven to both implementations (1..8).
- SETTLE, 1, clock cycles vec_out is held before sampling (1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a full sweep; sampled only in IDLE.
- ref_in  input  1  output of reference implementation.
- dut_in  input  1  output of implementation under test.
- vec_out  output  N_IN  input vector driven to both implementations.
- busy  output  1  high while sweeping (SETTLE or COMPARE state).
- done  output  1  one-cycle pulse when a sweep ends.
- pass  output  1  high when the last sweep had err_cnt==0; held until next start.
- err_cnt  output  N_IN+1  mismatches in last/current sweep.
- first_err_vec  output  N_IN  vec_out value of first mismatch.
- first_err_valid  output  1  first_err_vec holds a captured value.

Behaviour:
- Reset is asynchronous and active-low. Clock is `clk` and reset is `rst_n`; this is fixed.
- Reset values:
  - state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_cnt=0.
  - first_err_vec=0, first_err_valid=0, settle counter=0.
- States: IDLE, SETTLE, COMPARE, DONE (one-hot or binary; encoding from package).
- IDLE:
  - start=1 moves to SETTLE.
  - On that same edge: vec_out<=0, err_cnt<=0, first_err_valid<=0, first_err_vec<=0, pass<=0, settle counter<=SETTLE-1.
  - start=0 stays in IDLE; outputs hold.
- SETTLE:
  - Counter decrements each cycle.
  - At counter==0, go to COMPARE.
  - vec_out is held for exactly SETTLE cycles before the compare cycle.
- COMPARE: sample ref_in and dut_in this cycle. On mismatch (ref_in!=dut_in):
  - err_cnt<=err_cnt+1.
  - If first_err_valid==0, capture first_err_vec<=vec_out and set first_err_valid<=1.
- COMPARE exit:
  - If vec_out == all-ones, go to DONE.
  - Otherwise vec_out<=vec_out+1, reload the settle counter, and go to SETTLE.
- DONE:
  - done=1 for this single cycle.
  - pass<=(err_cnt==0), with err_cnt already including the final compare.
  - Go to IDLE.
- Timing:
  - Sweep length from the start-accept edge to the done pulse: 2^N_IN*(SETTLE+1) cycles, then 1 DONE cycle.
  - Defaults: 8 cycles, done asserted in cycle 9.
- Width: err_cnt is N_IN+1 bits, so 2^N_IN mismatches cannot overflow; no saturation is needed.
- start is ignored while busy or in DONE; there is no queueing.
- Results (pass, err_cnt, first_err_*) stay stable in IDLE until the next accepted start.
- vec_out stays at its final value (all-ones) after the sweep.
- rst_n asserted mid-sweep: immediate return to reset values. No done pulse, and the partial count is discarded.
- X or Z on ref_in/dut_in: a case-inequality compare (!==) counts X as a mismatch, so undriven or multiply-driven nets fail.

Optional Feature:
- Macro: TRUTH_TABLE_SEQ_HALT_ON_MISMATCH_EN.
- Defined: the first mismatch in COMPARE goes directly to DONE. err_cnt=1, vec_out holds the failing vector, and the sweep is shortened.
- Undefined: the sweep always covers all 2^N_IN vectors and counts every mismatch.

Decomposition:
- Package tts_pkg holds:
  - State typedef (IDLE, SETTLE, COMPARE, DONE).
  - Localparam for the settle-counter width ($clog2(16)=4).
- One sub-module: tts_settle_timer, a loadable down-counter with load value SETTLE-1 and a zero flag.

Test Plan:
1. ref=a^b, dut=a^b, defaults, start pulse → done at cycle 9; pass=1, err_cnt=0, first_err_valid=0.
2. ref=a^b, dut=~(a&b) → mismatch only at 00; err_cnt=1, first_err_vec=2'b00, pass=0.
3. dut driven to X (multiply-driven net) at vectors 01 and 10 → err_cnt=2, first_err_vec=2'b01.
4. start held high for 20 cycles → exactly one sweep; a second sweep starts only on the IDLE cycle after the done pulse.
5. rst_n low at cycle 4 of a sweep → all outputs 0 immediately, no done pulse; a new start completes normally.
6. With TRUTH_TABLE_SEQ_HALT_ON_MISMATCH_EN and scenario 2 stimulus → done in cycle 3, err_cnt=1, vec_out=2'b00.

Source files
------------

// File: rtl/tts_pkg.sv
// tts_pkg: shared definitions for the truth-table sequencer.
//   state_t / S_* : sequencer FSM encoding (binary, legacy-style constants)
//   CNT_W         : settle-counter width, sized for SETTLE up to 15
package tts_pkg;

   localparam int CNT_W = $clog2(16);

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE    = 2'd0;
   localparam state_t S_SETTLE  = 2'd1;
   localparam state_t S_COMPARE = 2'd2;
   localparam state_t S_DONE    = 2'd3;

endpackage

// File: rtl/tts_settle_timer.sv
// tts_settle_timer: loadable down-counter that times how long vec_out is held.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with SETTLE-1
//   dec        : decrement (stops at zero)
//   zero       : counter is zero; the settle window ends this cycle
module tts_settle_timer
   import tts_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= LOAD_VAL;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks a shared input vector through all 2^N_IN
// values, waits SETTLE cycles per step, then compares a reference output
// against a DUT output and reports the mismatch count, first failing vector
// and a pass flag.
//   clk, rst_n       : clock, async active-low reset
//   start            : request a sweep (only honoured in IDLE)
//   ref_in, dut_in   : outputs of the two implementations under comparison
//   vec_out          : input vector driven to both implementations
//   busy             : sweep in progress (SETTLE or COMPARE)
//   done             : one-cycle pulse at sweep end
//   pass             : last sweep had no mismatches (held until next start)
//   err_cnt          : mismatches in the last/current sweep
//   first_err_vec    : vector of the first mismatch
//   first_err_valid  : first_err_vec holds a captured value
// Build option: define TRUTH_TABLE_SEQ_HALT_ON_MISMATCH_EN to end the sweep
// on the first mismatch (vec_out then holds the failing vector).
module truth_table_sequencer
   import tts_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            ref_in,
   input  logic            dut_in,
   output logic [N_IN-1:0] vec_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic [N_IN-1:0] first_err_vec,
   output logic            first_err_valid
);

   state_t state;
   logic   zero;
   logic   load;
   logic   dec;
   logic   mismatch;
   logic   last_vec;
   logic   halt;

   // Case inequality so an X/Z from a floating or contended net counts as a
   // failure instead of silently matching.
   assign mismatch = (ref_in !== dut_in);
   assign last_vec = &vec_out;

`ifdef TRUTH_TABLE_SEQ_HALT_ON_MISMATCH_EN
   assign halt = mismatch;
`else
   assign halt = 1'b0;
`endif

   // Reload on sweep start and whenever COMPARE steps to the next vector.
   assign load = ((state == S_IDLE) && start) ||
                 ((state == S_COMPARE) && !last_vec && !halt);
   assign dec  = (state == S_SETTLE);

   tts_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .dec   (dec),
      .zero  (zero)
   );

   assign busy = (state == S_SETTLE) || (state == S_COMPARE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         vec_out         <= '0;
         pass            <= 1'b0;
         err_cnt         <= '0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state           <= S_SETTLE;
                  vec_out         <= '0;
                  pass            <= 1'b0;
                  err_cnt         <= '0;
                  first_err_vec   <= '0;
                  first_err_valid <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (zero)
                  state <= S_COMPARE;
            end
            S_COMPARE: begin
               if (mismatch) begin
                  err_cnt <= err_cnt + 1'b1;
                  if (!first_err_valid) begin
                     first_err_vec   <= vec_out;
                     first_err_valid <= 1'b1;
                  end
               end
               if (last_vec || halt) begin
                  state <= S_DONE;
               end else begin
                  vec_out <= vec_out + 1'b1;
                  state   <= S_SETTLE;
               end
            end
            S_DONE: begin
               // err_cnt already includes the final compare here.
               pass  <= (err_cnt == '0);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer (N_IN=2, SETTLE=1).
// Expected sweep results come from a behavioural model of the walk and are
// queued when a sweep is started, then popped when done pulses.
module tb_truth_table_sequencer;

   localparam int N  = 2;
   localparam int ST = 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         ref_in;
   logic         dut_in;
   logic [N-1:0] vec_out;
   logic         busy;
   logic         done;
   logic         pass;
   logic [N:0]   err_cnt;
   logic [N-1:0] first_err_vec;
   logic         first_err_valid;

   int tests = 0;
   int fails = 0;
   int mode  = 0;

   typedef struct {
      int           cycles;
      logic [N:0]   err;
      logic [N-1:0] fev;
      logic         fv;
      logic         pass;
      logic [N-1:0] vec;
   } exp_t;

   exp_t sb[$];

   truth_table_sequencer #(.N_IN(N), .SETTLE(ST)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .ref_in          (ref_in),
      .dut_in          (dut_in),
      .vec_out         (vec_out),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_cnt         (err_cnt),
      .first_err_vec   (first_err_vec),
      .first_err_valid (first_err_valid)
   );

   always #5 clk = ~clk;

   // Reference implementation: a ^ b.
   function automatic logic ref_f(input logic [N-1:0] v);
      return ^v;
   endfunction

   // mode 0: correct XOR; mode 1: NAND (wrong only at 00);
   // mode 2: XOR with a contended-net fault at 01 and 10 (a 2-state
   // simulator cannot carry X, so the fault shows as the wrong level).
   function automatic logic dut_f(input int m, input logic [N-1:0] v);
      case (m)
         1:       return ~(&v);
         2:       return ((v == 2'b01) || (v == 2'b10)) ? ~(^v) : ^v;
         default: return ^v;
      endcase
   endfunction

   always_comb begin
      ref_in = ref_f(vec_out);
      dut_in = dut_f(mode, vec_out);
   end

   function automatic exp_t model(input int m);
      exp_t e;
      logic [N-1:0] v;
      e.cycles = 0;
      e.err    = '0;
      e.fev    = '0;
      e.fv     = 1'b0;
      e.vec    = '0;
      for (int i = 0; i < (1 << N); i++) begin
         v        = N'(i);
         e.vec    = v;
         e.cycles = e.cycles + ST + 1;
         if (ref_f(v) != dut_f(m, v)) begin
            e.err = e.err + 1'b1;
            if (!e.fv) begin
               e.fev = v;
               e.fv  = 1'b1;
            end
`ifdef TRUTH_TABLE_SEQ_HALT_ON_MISMATCH_EN
            break;
`endif
         end
      end
      e.cycles = e.cycles + 1;  // the DONE cycle
      e.pass   = (e.err == '0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare the outputs seen on the done cycle (and the cycle after) against
   // the head of the scoreboard.
   task automatic check_result(input string tag, input int cyc);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_cycles"}, 32'(cyc), 32'(e.cycles));
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e.err));
      chk({tag, "_first_vec"}, 32'(first_err_vec), 32'(e.fev));
      chk({tag, "_first_valid"}, 32'(first_err_valid), 32'(e.fv));
      chk({tag, "_vec_out"}, 32'(vec_out), 32'(e.vec));
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
      chk({tag, "_done_low"}, 32'(done), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_held_err"}, 32'(err_cnt), 32'(e.err));
   endtask

   task automatic run_sweep(input int m, input string tag);
      int cyc;
      logic seen;
      mode = m;
      sb.push_back(model(m));
      @(negedge clk);
      start = 1'b1;
      cyc   = 0;
      seen  = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            seen = 1'b1;
            cyc  = c;
            break;
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_result(tag, cyc);
   endtask

   initial begin
      int ndone;
      int dc[2];
      exp_t e;

      // Reset state
      #1;
      chk("rst_vec", 32'(vec_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      chk("rst_fv", 32'(first_err_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Matching pair, mismatch at 00, two contended vectors
      run_sweep(0, "xor");
      run_sweep(1, "nand");
      run_sweep(2, "contend");

      // start held high: second sweep only accepted on the IDLE cycle after done
      mode = 0;
      sb.push_back(model(0));
      sb.push_back(model(0));
      ndone = 0;
      dc[0] = 0;
      dc[1] = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (ndone < 2) dc[ndone] = c;
            ndone++;
         end
         if (c == 10) chk("hold_idle_busy", 32'(busy), 32'd0);
         if (c == 11) chk("hold_rearm_busy", 32'(busy), 32'd1);
      end
      start = 1'b0;
      chk("hold_ndone", 32'(ndone), 32'd2);
      e = sb.pop_front();
      chk("hold_done1", 32'(dc[0]), 32'(e.cycles));
      e = sb.pop_front();
      chk("hold_done2", 32'(dc[1]), 32'(2 * e.cycles + 1));
      chk("hold_err", 32'(err_cnt), 32'(e.err));
      chk("hold_pass", 32'(pass), 32'(e.pass));

      // Reset mid-sweep, then a clean sweep
      mode = 1;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vec", 32'(vec_out), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_err", 32'(err_cnt), 32'd0);
      chk("mid_rst_fvec", 32'(first_err_vec), 32'd0);
      chk("mid_rst_fv", 32'(first_err_valid), 32'd0);
      ndone = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("mid_rst_no_done", 32'(ndone), 32'd0);
      rst_n = 1'b1;
      run_sweep(1, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
